sel_arbiter: RTL and testbench

SEL_ARBITER -- requirements
Module: sel_arbiter

---
 rtl/sel_arbiter_pkg.sv | 10 +
 rtl/sel_arbiter_rr_pick.sv | 31 +++
 rtl/sel_arbiter.sv | 95 +++++++++
 tb/tb_sel_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_arbiter_pkg.sv
// rtl/sel_arbiter_pkg.sv - shared constants and types for the four-port selecting arbiter
package sel_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int OUT_W     = 5;

  typedef logic [1:0]           src_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/sel_arbiter_rr_pick.sv
// rtl/sel_arbiter_rr_pick.sv - combinational winner selection, round-robin or fixed priority
module rr_pick
  import sel_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  port_vec_t valid_i,
  input  src_t      last_i,
  output port_vec_t grant_o,
  output src_t      idx_o
);

  logic found;

  // Scan starts just after the previous winner; fixed mode always scans from port 0.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      src_t cand;
      cand = (FIXED_PRIO != 0) ? src_t'(k) : src_t'(last_i + src_t'(k + 1));
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/sel_arbiter.sv
// rtl/sel_arbiter.sv - four-port arbiter merging mixed-width inputs into one registered 5-bit signed stream
module sel_arbiter
  import sel_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    in0_valid,
  input  logic [1:0]              in0_data,
  output logic                    in0_ready,

  input  logic                    in1_valid,
  input  logic [3:0]              in1_data,
  output logic                    in1_ready,

  input  logic                    in2_valid,
  input  logic signed [3:0]       in2_data,
  output logic                    in2_ready,

  input  logic                    in3_valid,
  input  logic signed [3:0]       in3_data,
  output logic                    in3_ready,

  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_src
);

  port_vec_t                in_valid;
  port_vec_t                grant;
  src_t                     win_idx;
  logic                     can_load;
  logic                     accept;

  logic                     out_valid_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic signed [OUT_W-1:0]  out_data_d;
  src_t                     out_src_q;
  src_t                     last_q;

  assign in_valid = {in3_valid, in2_valid, in1_valid, in0_valid};

  rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .valid_i (in_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  // Readies are gated by rst_n so they drop the instant reset asserts.
  assign can_load  = !out_valid_q || out_ready;
  assign accept    = rst_n && can_load && (|in_valid);

  assign in0_ready = accept && grant[0];
  assign in1_ready = accept && grant[1];
  assign in2_ready = accept && grant[2];
  assign in3_ready = accept && grant[3];

  always_comb begin
    out_data_d = '0;
    case (win_idx)
      2'd0:    out_data_d = {3'b000, in0_data};
      2'd1:    out_data_d = {1'b0, in1_data};
      2'd2:    out_data_d = {in2_data[3], in2_data};
      default: out_data_d = {in3_data[3], in3_data};
    endcase
  end

  // last resets to the top index so port 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      last_q      <= src_t'(NUM_PORTS - 1);
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      out_src_q   <= win_idx;
      last_q      <= win_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_sel_arbiter.sv
// tb/tb_sel_arbiter.sv - directed self-checking bench for round-robin and fixed-priority arbiters
module tb_sel_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in0_valid, in1_valid, in2_valid, in3_valid;
  logic [1:0]        in0_data;
  logic [3:0]        in1_data;
  logic signed [3:0] in2_data, in3_data;
  logic              out_ready;

  logic              rr_in0_ready, rr_in1_ready, rr_in2_ready, rr_in3_ready;
  logic              rr_out_valid;
  logic signed [4:0] rr_out_data;
  logic [1:0]        rr_out_src;

  logic              fp_in0_ready, fp_in1_ready, fp_in2_ready, fp_in3_ready;
  logic              fp_out_valid;
  logic signed [4:0] fp_out_data;
  logic [1:0]        fp_out_src;

  logic [3:0]        rr_rdy, fp_rdy;

  int compared   = 0;
  int mismatched = 0;

  assign rr_rdy = {rr_in3_ready, rr_in2_ready, rr_in1_ready, rr_in0_ready};
  assign fp_rdy = {fp_in3_ready, fp_in2_ready, fp_in1_ready, fp_in0_ready};

  always #5 clk = ~clk;

  sel_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (rr_in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (rr_in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (rr_in2_ready),
    .in3_valid (in3_valid),
    .in3_data  (in3_data),
    .in3_ready (rr_in3_ready),
    .out_valid (rr_out_valid),
    .out_ready (out_ready),
    .out_data  (rr_out_data),
    .out_src   (rr_out_src)
  );

  sel_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (fp_in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (fp_in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (fp_in2_ready),
    .in3_valid (in3_valid),
    .in3_data  (in3_data),
    .in3_ready (fp_in3_ready),
    .out_valid (fp_out_valid),
    .out_ready (out_ready),
    .out_data  (fp_out_data),
    .out_src   (fp_out_src)
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    logic [4:0] word_of [4];
    logic [1:0] alt_seq [4];
    rr_seq  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    word_of = '{5'b00001, 5'b00010, 5'b00011, 5'b11111};
    alt_seq = '{2'd3, 2'd0, 2'd3, 2'd0};

    rst_n = 1'b0;
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 2'b11;
    in1_valid = 1'b0; in1_data = '0;
    in2_valid = 1'b0; in2_data = '0;
    in3_valid = 1'b0; in3_data = '0;

    #2;
    check("reset_out_valid", rr_out_valid, 5'd0);
    check("reset_out_data",  rr_out_data,  5'd0);
    check("reset_out_src",   rr_out_src,   5'd0);
    check("reset_rr_ready",  rr_rdy,       5'd0);
    check("reset_fp_ready",  fp_rdy,       5'd0);
    tick;
    tick;

    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("first_ready", rr_rdy, 5'b00001);
    tick;
    check("first_valid", rr_out_valid, 5'd1);
    check("first_data",  rr_out_data,  5'sd3);
    check("first_src",   rr_out_src,   5'd0);

    in0_valid = 1'b0;
    in2_valid = 1'b1; in2_data = 4'b1000;
    #1 check("sext_ready", rr_rdy, 5'b00100);
    tick;
    check("sext_data", rr_out_data, 5'b11000);
    check("sext_src",  rr_out_src,  5'd2);

    in2_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 4'b1000;
    #1 check("zext_ready", rr_rdy, 5'b00010);
    tick;
    check("zext_data", rr_out_data, 5'b01000);
    check("zext_src",  rr_out_src,  5'd1);

    in1_valid = 1'b0;
    tick;
    check("drain_valid", rr_out_valid, 5'd0);
    check("drain_data",  rr_out_data,  5'b01000);
    check("drain_src",   rr_out_src,   5'd1);

    in0_valid = 1'b1; in0_data = 2'b01;
    in1_valid = 1'b1; in1_data = 4'd2;
    in2_valid = 1'b1; in2_data = 4'sd3;
    in3_valid = 1'b1; in3_data = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr_ready_%0d", k), rr_rdy, 5'(4'b0001 << rr_seq[k]));
      tick;
      check($sformatf("rr_src_%0d", k),  rr_out_src,  rr_seq[k]);
      check($sformatf("rr_data_%0d", k), rr_out_data, word_of[rr_seq[k]]);
    end

    out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
    in3_data  = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("bp_ready_%0d", k), rr_rdy, 5'd0);
      tick;
      check($sformatf("bp_valid_%0d", k), rr_out_valid, 5'd1);
      check($sformatf("bp_data_%0d", k),  rr_out_data,  5'b00011);
      check($sformatf("bp_src_%0d", k),   rr_out_src,   5'd2);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", rr_rdy, 5'b01000);
    tick;
    check("bp_release_src",  rr_out_src,  5'd3);
    check("bp_release_data", rr_out_data, 5'b00101);

    in3_valid = 1'b0;
    in2_valid = 1'b1; in2_data = 4'sd6;
    #1 check("pre_rst_ready", rr_rdy, 5'b00100);
    tick;
    check("pre_rst_src", rr_out_src, 5'd2);
    in2_valid = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", rr_out_valid, 5'd0);
    check("async_data",  rr_out_data,  5'd0);
    check("async_src",   rr_out_src,   5'd0);
    check("async_ready", rr_rdy,       5'd0);
    #2 rst_n = 1'b1;
    in0_valid = 1'b1; in0_data = 2'b10;
    in1_valid = 1'b1;
    in3_valid = 1'b1; in3_data = 4'b1001;
    out_ready = 1'b1;
    #1 check("post_rst_ready", rr_rdy, 5'b00001);
    tick;
    check("post_rst_src",  rr_out_src,  5'd0);
    check("post_rst_data", rr_out_data, 5'b00010);

    in1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("fp_ready_%0d", k), fp_rdy, 5'b00001);
      tick;
      check($sformatf("fp_src_%0d", k), fp_out_src, 5'd0);
      check($sformatf("rr_alt_%0d", k), rr_out_src, alt_seq[k]);
    end
    in0_valid = 1'b0;
    #1 check("fp_p3_ready", fp_rdy, 5'b01000);
    tick;
    check("fp_p3_src",  fp_out_src,  5'd3);
    check("fp_p3_data", fp_out_data, 5'b11001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
